// File: rtl/student_fir_seq_if.sv
// Coefficient-write, sample-input and result-output signals of the sequential FIR.
// Only clock and reset stay outside the interface.
interface student_fir_seq_if #(
    parameter int DATA_W   = 16,
    parameter int COEFF_W  = 16,
    parameter int NUM_TAPS = 8
);
    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int ACC_W = DATA_W + COEFF_W + TAP_W;

    logic               coeff_we_i;
    logic [TAP_W-1:0]   coeff_addr_i;
    logic [COEFF_W-1:0] coeff_wdata_i;
    logic               sample_valid_i;
    logic               sample_ready_o;
    logic [DATA_W-1:0]  sample_i;
    logic               result_valid_o;
    logic               result_ready_i;
    logic [ACC_W-1:0]   result_o;
    logic               busy_o;

    modport master (
        output coeff_we_i, coeff_addr_i, coeff_wdata_i,
        output sample_valid_i, sample_i, result_ready_i,
        input  sample_ready_o, result_valid_o, result_o, busy_o
    );

    modport slave (
        input  coeff_we_i, coeff_addr_i, coeff_wdata_i,
        input  sample_valid_i, sample_i, result_ready_i,
        output sample_ready_o, result_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/student_fir_seq.sv
// Sequential FIR: one signed multiply-accumulate per cycle over a NUM_TAPS delay line,
// with a writable coefficient bank and valid/ready handshakes on both sides.
module student_fir_seq #(
    parameter int DATA_W   = 16,
    parameter int COEFF_W  = 16,
    parameter int NUM_TAPS = 8
) (
    input logic               clk_i,
    input logic               rst_ni,
    student_fir_seq_if.slave  bus
);
    localparam int TAP_W  = $clog2(NUM_TAPS);
    localparam int ACC_W  = DATA_W + COEFF_W + TAP_W;
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int ADDR_W = TAP_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic signed [DATA_W-1:0]  x_r [NUM_TAPS];
    logic signed [COEFF_W-1:0] c_r [NUM_TAPS];
    logic signed [ACC_W-1:0]   acc_r;
    logic [TAP_W-1:0]          tap_r;
    logic signed [ACC_W-1:0]   result_r;
    logic                      sample_ready_r;
    logic                      result_valid_r;
    logic                      busy_r;

    logic                      accept_s;
    logic                      take_s;
    logic                      last_tap_s;
    logic                      coeff_wr_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   acc_next_s;

    // Next-state decode, handshake qualification and the MAC datapath.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        take_s     = 1'b0;
        coeff_wr_s = 1'b0;
        last_tap_s = (tap_r == TAP_W'(NUM_TAPS - 1));
        prod_s     = PROD_W'(x_r[tap_r]) * PROD_W'(c_r[tap_r]);
        acc_next_s = acc_r + ACC_W'(prod_s);
        case (state_r)
            IDLE: begin
                coeff_wr_s = bus.coeff_we_i &&
                             ({1'b0, bus.coeff_addr_i} < ADDR_W'(NUM_TAPS));
                if (bus.sample_valid_i) begin
                    accept_s = 1'b1;
                    state_s  = MAC;
                end else begin
                    state_s  = IDLE;
                end
            end
            MAC: begin
                if (last_tap_s) begin
                    state_s = OUT;
                end else begin
                    state_s = MAC;
                end
            end
            OUT: begin
                if (bus.result_ready_i) begin
                    take_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, accumulator, tap counter and registered status/result outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r        <= IDLE;
            acc_r          <= '0;
            tap_r          <= '0;
            result_r       <= '0;
            sample_ready_r <= 1'b1;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            sample_ready_r <= (state_s == IDLE);
            result_valid_r <= (state_s == OUT);
            busy_r         <= (state_s != IDLE);
            if (accept_s) begin
                acc_r <= '0;
                tap_r <= '0;
            end else if (state_r == MAC) begin
                acc_r <= acc_next_s;
                if (!last_tap_s) begin
                    tap_r <= tap_r + TAP_W'(1);
                end
            end
            // The result register is loaded with the final sum so it is stable through OUT.
            if ((state_r == MAC) && last_tap_s) begin
                result_r <= acc_next_s;
            end else if (take_s) begin
                result_r <= '0;
            end
        end
    end

    // Delay line shifts only on an accepted sample.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_r[k] <= '0;
            end
        end else if (accept_s) begin
            for (int k = NUM_TAPS - 1; k > 0; k--) begin
                x_r[k] <= x_r[k-1];
            end
            x_r[0] <= bus.sample_i;
        end
    end

    // Coefficient bank; a write in the accepting cycle lands before the first MAC reads it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                c_r[k] <= '0;
            end
        end else if (coeff_wr_s) begin
            c_r[bus.coeff_addr_i] <= bus.coeff_wdata_i;
        end
    end

    assign bus.sample_ready_o = sample_ready_r;
    assign bus.result_valid_o = result_valid_r;
    assign bus.result_o       = result_r;
    assign bus.busy_o         = busy_r;

endmodule

// File: tb/tb_student_fir_seq.sv
// Directed bench for student_fir_seq with default parameters (8 taps, 16-bit data and coefficients).
module tb_student_fir_seq;
    localparam int DATA_W   = 16;
    localparam int COEFF_W  = 16;
    localparam int NUM_TAPS = 8;
    localparam int ACC_W    = 35;

    logic clk_i;
    logic rst_ni;
    int   vectors;
    int   miscompares;

    student_fir_seq_if #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .NUM_TAPS(NUM_TAPS)) bus ();

    student_fir_seq #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .NUM_TAPS(NUM_TAPS)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_coeff(input int addr, input logic [COEFF_W-1:0] data);
        bus.coeff_we_i    = 1'b1;
        bus.coeff_addr_i  = addr[2:0];
        bus.coeff_wdata_i = data;
        tick();
        bus.coeff_we_i    = 1'b0;
    endtask

    task automatic send_sample(input logic [DATA_W-1:0] s);
        int n;
        n = 0;
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = s;
        while (bus.sample_ready_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL sample_ready_timeout: ready=%b required 1", bus.sample_ready_o);
        end
        tick();
        bus.sample_valid_i = 1'b0;
    endtask

    task automatic get_result(output logic [ACC_W-1:0] val);
        int n;
        n = 0;
        bus.result_ready_i = 1'b0;
        while (bus.result_valid_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL result_valid_timeout: valid=%b required 1", bus.result_valid_o);
        end
        val = bus.result_o;
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
    endtask

    task automatic flush_zeros();
        logic [ACC_W-1:0] r;
        for (int i = 0; i < NUM_TAPS; i++) begin
            send_sample('0);
            get_result(r);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        vectors++;
        if (bus.sample_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", bus.sample_ready_o);
        end
        vectors++;
        if (bus.result_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 0", bus.result_valid_o);
        end
        vectors++;
        if (bus.result_o !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_result: got %0d want 0", bus.result_o);
        end
        vectors++;
        if (bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", bus.busy_o);
        end
    endtask

    task automatic test_impulse();
        logic [ACC_W-1:0] r;
        for (int k = 0; k < NUM_TAPS; k++) begin
            write_coeff(k, 16'(k + 1));
        end
        for (int i = 0; i < NUM_TAPS; i++) begin
            send_sample((i == 0) ? 16'd1 : 16'd0);
            get_result(r);
            vectors++;
            if (r !== 35'(i + 1)) begin
                miscompares++;
                $display("FAIL impulse[%0d]: got %0d want %0d", i, r, i + 1);
            end
        end
    endtask

    task automatic test_latency();
        // delay line is all zero except x[7]=1, which falls off when 3 is shifted in
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = 16'd3;
        tick();
        bus.sample_valid_i = 1'b0;
        vectors++;
        if (bus.busy_o !== 1'b1 || bus.sample_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_accept: busy=%b ready=%b want busy=1 ready=0",
                     bus.busy_o, bus.sample_ready_o);
        end
        for (int i = 1; i < NUM_TAPS; i++) begin
            tick();
            vectors++;
            if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                miscompares++;
                $display("FAIL latency_E+%0d: valid=%b busy=%b want valid=0 busy=1",
                         i, bus.result_valid_o, bus.busy_o);
            end
        end
        tick();
        vectors++;
        if (bus.result_valid_o !== 1'b1 || bus.result_o !== 35'd3) begin
            miscompares++;
            $display("FAIL latency_E+8: valid=%b result=%0d want valid=1 result=3",
                     bus.result_valid_o, bus.result_o);
        end
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        vectors++;
        if (bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_done_busy: got %b want 0", bus.busy_o);
        end
    endtask

    task automatic test_backpressure();
        logic [ACC_W-1:0] r;
        int n;
        // x = [5,3,0..] -> 5*1 + 3*2 = 11
        send_sample(16'd5);
        n = 0;
        while (bus.result_valid_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = 16'd77;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus.result_valid_o !== 1'b1 || bus.result_o !== 35'd11 || bus.sample_ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: valid=%b result=%0d ready=%b want 1/11/0",
                         i, bus.result_valid_o, bus.result_o, bus.sample_ready_o);
            end
        end
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        bus.sample_valid_i = 1'b0;
        // 77 must not have entered: x = [0,5,3,..] -> 5*2 + 3*3 = 19
        send_sample(16'd0);
        get_result(r);
        vectors++;
        if (r !== 35'd19) begin
            miscompares++;
            $display("FAIL backpressure_no_consume: got %0d want 19", r);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int period;
        bus.result_ready_i = 1'b1;
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = 16'd0;
        n = 0;
        while (bus.result_valid_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        period = 0;
        do begin
            tick();
            period++;
        end while (bus.result_valid_o !== 1'b1 && period < 100);
        vectors++;
        if (period !== NUM_TAPS + 2) begin
            miscompares++;
            $display("FAIL back_to_back_period: got %0d want %0d", period, NUM_TAPS + 2);
        end
        bus.sample_valid_i = 1'b0;
        n = 0;
        while (bus.busy_o !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        bus.result_ready_i = 1'b0;
    endtask

    task automatic test_coeff_in_mac();
        logic [ACC_W-1:0] r;
        flush_zeros();
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = 16'd1;
        tick();
        bus.sample_valid_i = 1'b0;
        tick();
        write_coeff(0, 16'd100);
        get_result(r);
        vectors++;
        if (r !== 35'd1) begin
            miscompares++;
            $display("FAIL coeff_mac_first: got %0d want 1", r);
        end
        // x = [1,1,0..] with old c0=1, c1=2 -> 3
        send_sample(16'd1);
        get_result(r);
        vectors++;
        if (r !== 35'd3) begin
            miscompares++;
            $display("FAIL coeff_mac_readback: got %0d want 3", r);
        end
    endtask

    task automatic test_same_cycle_write();
        logic [ACC_W-1:0] r;
        flush_zeros();
        bus.coeff_we_i     = 1'b1;
        bus.coeff_addr_i   = 3'd0;
        bus.coeff_wdata_i  = 16'd7;
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = 16'd2;
        tick();
        bus.coeff_we_i     = 1'b0;
        bus.sample_valid_i = 1'b0;
        get_result(r);
        vectors++;
        if (r !== 35'd14) begin
            miscompares++;
            $display("FAIL same_cycle_write: got %0d want 14", r);
        end
    endtask

    task automatic test_extremes();
        logic [ACC_W-1:0] r;
        logic [63:0]      e;
        for (int k = 0; k < NUM_TAPS; k++) begin
            write_coeff(k, 16'h8000);
        end
        flush_zeros();
        for (int i = 1; i <= NUM_TAPS; i++) begin
            send_sample(16'h8000);
            get_result(r);
            e = 64'(i) * 64'd1073741824;
            vectors++;
            if (r !== e[ACC_W-1:0]) begin
                miscompares++;
                $display("FAIL extremes[%0d]: got %0d want %0d", i, r, e);
            end
        end
    endtask

    task automatic test_reset_in_mac();
        logic [ACC_W-1:0] r;
        int seen;
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = 16'd1;
        tick();
        bus.sample_valid_i = 1'b0;
        tick();
        tick();
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        vectors++;
        if (bus.busy_o !== 1'b0 || bus.sample_ready_o !== 1'b1 || bus.result_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mac_state: busy=%b ready=%b valid=%b want 0/1/0",
                     bus.busy_o, bus.sample_ready_o, bus.result_valid_o);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.result_valid_o === 1'b1) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_mac_no_emit: valid seen %0d cycles want 0", seen);
        end
        send_sample(16'd1);
        get_result(r);
        vectors++;
        if (r !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_mac_coeffs_cleared: got %0d want 0", r);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors            = 0;
        miscompares        = 0;
        rst_ni             = 1'b1;
        bus.coeff_we_i     = 1'b0;
        bus.coeff_addr_i   = '0;
        bus.coeff_wdata_i  = '0;
        bus.sample_valid_i = 1'b0;
        bus.sample_i       = '0;
        bus.result_ready_i = 1'b0;
        test_reset();
        test_impulse();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_coeff_in_mac();
        test_same_cycle_write();
        test_extremes();
        test_reset_in_mac();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
